// File: rtl/seq_booth_mul_if.sv
// ---------------------------------------------------------------------------
// seq_booth_mul_if
//   Handshake/operand bundle between the control unit and the sequential
//   Booth multiplier.
//
//   Signals (DATA_WIDTH = W):
//     start  ctrl -> mul   request, honoured only while the multiplier is idle
//     A      ctrl -> mul   W-bit signed multiplicand
//     B      ctrl -> mul   W-bit signed multiplier
//     busy   mul  -> ctrl  multiply in progress
//     done   mul  -> ctrl  one-cycle pulse, Z freshly updated
//     Z      mul  -> ctrl  2W-bit signed product {HI, LO}
//
//   Modports: master = control unit side, slave = multiplier side.
// ---------------------------------------------------------------------------
interface seq_booth_mul_if #(
    parameter int DATA_WIDTH = 32
);
    logic                    start;
    logic [DATA_WIDTH-1:0]   A;
    logic [DATA_WIDTH-1:0]   B;
    logic                    busy;
    logic                    done;
    logic [2*DATA_WIDTH-1:0] Z;

    modport master (
        output start, A, B,
        input  busy, done, Z
    );

    modport slave (
        input  start, A, B,
        output busy, done, Z
    );
endinterface

// File: rtl/seq_booth_mul.sv
// ---------------------------------------------------------------------------
// seq_booth_mul
//   Sequential signed W x W -> 2W multiplier using radix-4 Booth recoding,
//   retiring two multiplier bits per cycle (N = W/2 iterations).
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset (discards any operation in flight)
//     bus    seq_booth_mul_if.slave: start/A/B in, busy/done/Z out
//
//   Timing: start accepted in IDLE at edge E -> busy from E, result loaded
//   into Z at edge E+N, done high for the cycle after E+N. Z only changes on
//   completion or reset.
//
//   Build option ZERO_BYPASS_EN: when defined, a start with A==0 or B==0 is
//   answered directly from IDLE (Z=0, done the next cycle, busy stays 0).
// ---------------------------------------------------------------------------
module seq_booth_mul #(
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_booth_mul_if.slave bus
);
    localparam int W  = DATA_WIDTH;
    localparam int PW = W + 2;          // accumulator holds +/-2M without overflow
    localparam int N  = W / 2;
    localparam int CW = $clog2(N + 1);

    generate
        if ((W % 2) != 0 || W < 4) begin : g_bad_width
            $error("seq_booth_mul: DATA_WIDTH must be even and >= 4");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e          state_q,  state_d;
    logic [PW-1:0]   mcand_q,  mcand_d;
    logic [PW-1:0]   p_q,      p_d;
    logic [W-1:0]    mplier_q, mplier_d;
    logic            qm1_q,    qm1_d;      // q[-1], bit shifted out last step
    logic [CW-1:0]   cnt_q,    cnt_d;
    logic [2*W-1:0]  z_q,      z_d;
    logic            done_q,   done_d;

    // ------------------------------------------------------------------
    // Booth step datapath: select partial product, accumulate, then shift
    // {P, Mplier, q[-1]} right arithmetically by two.
    // ------------------------------------------------------------------
    logic [2:0]      trip;
    logic [PW-1:0]   addend;
    logic [PW-1:0]   sum;
    logic [PW-1:0]   p_shr;
    logic [W-1:0]    mplier_shr;

    always_comb begin
        trip = {mplier_q[1:0], qm1_q};
        case (trip)
            3'b001, 3'b010: addend = mcand_q;
            3'b011:         addend = mcand_q << 1;
            3'b100:         addend = -(mcand_q << 1);
            3'b101, 3'b110: addend = -mcand_q;
            default:        addend = '0;
        endcase
        sum        = p_q + addend;
        p_shr      = {{2{sum[PW-1]}}, sum[PW-1:2]};
        mplier_shr = {sum[1:0], mplier_q[W-1:2]};
    end

    // Short-circuit for zero operands; constant 0 when the option is off.
    logic bypass;
    always_comb begin
`ifdef ZERO_BYPASS_EN
        bypass = (bus.A == '0) || (bus.B == '0);
`else
        bypass = 1'b0;
`endif
    end

    // ------------------------------------------------------------------
    // Next-state / control
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        p_d      = p_q;
        mplier_d = mplier_q;
        qm1_d    = qm1_q;
        cnt_d    = cnt_q;
        z_d      = z_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start && bypass) begin
                    z_d    = '0;
                    done_d = 1'b1;
                end else if (bus.start) begin
                    mcand_d  = {{2{bus.A[W-1]}}, bus.A};
                    mplier_d = bus.B;
                    qm1_d    = 1'b0;
                    p_d      = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                p_d      = p_shr;
                mplier_d = mplier_shr;
                qm1_d    = mplier_q[1];
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    // Final step: low 2W bits of {P, Mplier} are the product.
                    z_d     = {p_shr[W-1:0], mplier_shr};
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            p_q      <= '0;
            mplier_q <= '0;
            qm1_q    <= 1'b0;
            cnt_q    <= '0;
            z_q      <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            p_q      <= p_d;
            mplier_q <= mplier_d;
            qm1_q    <= qm1_d;
            cnt_q    <= cnt_d;
            z_q      <= z_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = done_q;
    assign bus.Z    = z_q;
endmodule

// File: tb/tb_seq_booth_mul.sv
// ---------------------------------------------------------------------------
// tb_seq_booth_mul
//   Scoreboard bench for seq_booth_mul (W=32). Expected products are queued
//   when an operation is launched and popped by a negedge monitor on done.
//   The monitor also checks that Z never moves outside a done cycle.
// ---------------------------------------------------------------------------
module tb_seq_booth_mul;
    localparam int W = 32;
    localparam int N = W / 2;
`ifdef ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    seq_booth_mul_if #(.DATA_WIDTH(W)) mif ();
    seq_booth_mul #(.DATA_WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (mif.slave)
    );

    int             total = 0;
    int             bad   = 0;
    int             cyc   = 0;
    logic [2*W-1:0] sb_q[$];
    logic [2*W-1:0] last_z = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [2*W-1:0] got,
                       input logic [2*W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return sa * sb;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Result scoreboard + Z stability monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            last_z = mif.Z;
        end else if (mif.done) begin
            chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) chk("z_result", mif.Z, sb_q.pop_front());
            last_z = mif.Z;
        end else begin
            chk("z_hold", mif.Z, last_z);
        end
    end

    // One operation: launch, then measure latency and busy cycles.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
        int n, busy_n, exp_lat;
        mif.start = 1'b1;
        mif.A     = a;
        mif.B     = b;
        sb_q.push_back(ref_mul(a, b));
        tick();                         // edge E
        mif.start = 1'b0;
        mif.A     = $urandom;
        mif.B     = $urandom;
        n      = 0;
        busy_n = 0;
        while (!mif.done && n <= 40) begin
            if (mif.busy) busy_n++;
            tick();
            n++;
        end
        exp_lat = (BYP && (a == '0 || b == '0)) ? 0 : N;
        chk("latency", 64'(n), 64'(exp_lat));
        chk("busy_cycles", 64'(busy_n), 64'(exp_lat));
        tick();
        chk("done_pulse", 64'(mif.done), 64'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin : stim
        int n, ndone, prev;
        mif.start = 1'b0;
        mif.A     = '0;
        mif.B     = '0;

        // Reset state
        #2 rst_n = 1'b0;
        #10;
        chk("rst_busy", 64'(mif.busy), 64'd0);
        chk("rst_done", 64'(mif.done), 64'd0);
        chk("rst_z", mif.Z, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed corners
        run_op(32'd7, 32'hFFFF_FFFD);
        chk("z_7x-3", mif.Z, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(32'h8000_0000, 32'h8000_0000);
        chk("z_minxmin", mif.Z, 64'h4000_0000_0000_0000);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("z_m1xm1", mif.Z, 64'h0000_0000_0000_0001);
        run_op(32'h7FFF_FFFF, 32'h8000_0000);
        chk("z_maxxmin", mif.Z, 64'hC000_0000_8000_0000);

        // Random operands
        for (int i = 0; i < 6; i++) run_op($urandom, $urandom);

        // start during RUN is ignored
        mif.start = 1'b1; mif.A = 32'd5; mif.B = 32'd6;
        sb_q.push_back(64'd30);
        tick();
        mif.start = 1'b0;
        repeat (4) tick();
        mif.start = 1'b1; mif.A = 32'd9; mif.B = 32'd9;
        tick();
        mif.start = 1'b0;
        n = 5;
        while (!mif.done && n <= 40) begin tick(); n++; end
        chk("ign_latency", 64'(n), 64'(N));
        repeat (6) tick();
        chk("ign_z_kept", mif.Z, 64'd30);
        chk("ign_idle", 64'(mif.busy), 64'd0);

        // Async reset mid-operation
        mif.start = 1'b1; mif.A = 32'd100; mif.B = 32'd200;
        tick();
        mif.start = 1'b0;
        repeat (7) tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(mif.busy), 64'd0);
        chk("mid_rst_done", 64'(mif.done), 64'd0);
        chk("mid_rst_z", mif.Z, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run_op(32'd3, 32'd4);
        chk("z_after_rst", mif.Z, 64'd12);

        // start held high: back-to-back every N+1 cycles
        for (int i = 0; i < 3; i++) sb_q.push_back(64'hFFFF_FFFF_FFFF_FFFE);
        mif.start = 1'b1; mif.A = 32'hFFFF_FFFF; mif.B = 32'd2;
        ndone = 0;
        prev  = 0;
        for (int i = 0; i < 100 && ndone < 3; i++) begin
            tick();
            if (mif.done) begin
                ndone++;
                if (ndone > 1) chk("held_period", 64'(cyc - prev), 64'(N + 1));
                prev = cyc;
                if (ndone == 3) mif.start = 1'b0;
            end
        end
        mif.start = 1'b0;
        chk("held_count", 64'(ndone), 64'd3);
        tick();

        // Zero operand (bypass or full path depending on build)
        run_op(32'd0, 32'h1234_5678);
        chk("z_zero", mif.Z, 64'd0);
        run_op(32'hDEAD_BEEF, 32'd0);

        repeat (3) tick();
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_booth_mul.md
Name: seq_booth_mul

Overview:
- Sequential signed multiplier for the ALU MUL operation. It is the inverse operation of the divide path.
- Computes A*B in two's complement using radix-4 Booth recoding, 2 multiplier bits per cycle.
- Places the product as {HI, LO} on Z: Z[2W-1:W] goes to the HI register and Z[W-1:0] goes to the LO register.
- Driven by the control unit through a start/busy/done handshake.

Parameters:
DATA_WIDTH  32  operand width W; must be even and >= 4; iteration count N = W/2

Ports:
clk    input   1           rising-edge clock
rst_n  input   1           asynchronous active-low reset
start  input   1           request; sampled only while idle
A      input   DATA_WIDTH  multiplicand, signed; sampled with accepted start
B      input   DATA_WIDTH  multiplier, signed; sampled with accepted start
busy   output  1           multiply in progress
done   output  1           one-cycle pulse; Z valid and updated
Z      output  2*DATA_WIDTH  signed product {HI, LO}

Behaviour:
- Reset (rst_n low, asynchronous, any state, including mid-operation):
  - state=IDLE; busy=0; done=0; Z=0; counter=0.
  - The in-flight operation is discarded.
- States: IDLE, RUN.
- IDLE:
  - busy=0.
  - If start=1 at rising edge E: latch A into Mcand (sign-extended to W+2) and B into Mplier with appended bit q[-1]=0.
  - Clear accumulator P (W+2 bits); counter=0; go to RUN.
  - busy=1 from E.
- RUN, at each edge:
  - Examine triplet {q[1], q[0], q[-1]}. Add to P: 000/111 -> 0; 001/010 -> +M; 011 -> +2M; 100 -> -2M; 101/110 -> -M.
  - Arithmetic right-shift the combined {P, Mplier, q[-1]} by 2.
  - counter increments.
- Completion:
  - On the N-th RUN edge (E+N), Z is loaded with the low 2W bits of the final {P, Mplier}.
  - done=1 for exactly the cycle following E+N.
  - busy=0 and state=IDLE at E+N.
  - Latency is N=16 cycles for W=32.
- Z holds its value until the next completion or reset. It never changes while busy.
- Width rules:
  - Full-precision result, no overflow or saturation.
  - Internal accumulator must be W+2 bits so ±2M cannot overflow.
  - Example: (-2^(W-1))*(-2^(W-1)) = 2^(2W-2) = 0x4000_0000_0000_0000 for W=32.
- start while busy=1 is ignored; operands are not resampled. A/B changing during RUN has no effect.
- start=1 in the same cycle done=1 (state IDLE): accepted. The new operation begins; done still pulses only once for the previous result.
- Back-to-back throughput: one result per N+1 cycles minimum.
- start held high continuously: a new operation starts every time the block returns to IDLE.

Optional Feature:
ZERO_BYPASS_EN
- Defined:
  - In IDLE, if start=1 and (A==0 or B==0), skip RUN.
  - At edge E, Z=0 and done=1 for the following cycle, with busy staying 0. Latency is 1 cycle.
- Undefined:
  - Zero operands take the full N-cycle RUN path and produce Z=0 with standard latency.
- All other behaviour is identical in both builds.

Test Plan:
- A=7, B=-3 (0xFFFFFFFD), pulse start -> busy=1 for 16 cycles; done pulse at cycle 16; Z=0xFFFF_FFFF_FFFF_FFEB.
- A=0x80000000, B=0x80000000 -> Z=0x4000_0000_0000_0000. A=0xFFFFFFFF, B=0xFFFFFFFF -> Z=0x0000_0000_0000_0001. A=0x7FFFFFFF, B=0x80000000 -> Z=0xC000_0000_8000_0000.
- A=5, B=6 started; at cycle 5 assert start with A=9, B=9 -> ignored; Z=30 at done; Z unchanged until next completion.
- Start A=100, B=200; drive rst_n low at cycle 8 -> busy=0, done=0, Z=0 immediately. After release, start A=3, B=4 -> Z=12 after 16 cycles; no stray done.
- start held high with A=-1, B=2 -> done pulses every 17 cycles; Z=0xFFFF_FFFF_FFFF_FFFE each time.
- A=0, B=0x12345678: with ZERO_BYPASS_EN -> done one cycle after start, busy never 1, Z=0. Without it -> done after 16 cycles, Z=0.
